// File: rtl/mux4_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mux4_arb_pkg : shared encodings and helpers for the 4-way arbiter
// Rev 1.0
// ------------------------------------------------------------------
package mux4_arb_pkg;

  localparam int N_REQ            = 4;
  localparam int IDX_W            = 2;
  localparam int CNT_W            = 8;
  localparam int HOLD_MAX_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    onehot4 = N_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mux4_arbiter_if : request/grant bundle plus external mux selects
// Rev 1.0
// ------------------------------------------------------------------
interface mux4_arbiter_if
  import mux4_arb_pkg::*;
;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             s1;
  logic             s2;
  logic             valid;

  modport master (output req, input gnt, s1, s2, valid);
  modport slave  (input req, output gnt, s1, s2, valid);
endinterface
`default_nettype wire

// File: rtl/mux4_arbiter_rr_pick4.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick4 : combinational round-robin pick, searching last+1 .. last
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mux4_arbiter : round-robin grant with hold limit and a one-cycle gap
// Rev 1.0
// ------------------------------------------------------------------
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
)
(
  input  logic          clk,
  input  logic          reset_n,
  mux4_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic             valid_q, valid_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             others_req;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // While granted, last_q is also the owner's index.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    owner_req  = bus.req[last_q];
    others_req = |(bus.req & ~onehot4(last_q));

    case (state_q)
      ST_GRANT: begin
        if (!owner_req || (cnt_q == CNT_LIMIT && others_req)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (cnt_q != CNT_LIMIT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; selects hold when nothing wins.
        if (pick_any) begin
          state_d = ST_GRANT;
          last_d  = pick_idx;
          cnt_d   = '0;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = sel_q[1];
  assign bus.s2    = sel_q[0];
  assign bus.valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mux4_arbiter : scoreboard bench with a behavioural arbiter model
// Rev 1.0
// ------------------------------------------------------------------
module tb_mux4_arbiter;
  import mux4_arb_pkg::*;

  localparam int HM       = 8;
  localparam int WAIT_MAX = 3 * (HM + 1);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mux4_arbiter_if bus ();

  mux4_arbiter #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  bit   stim_done = 1'b0;
  int   drain     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: who owns the mux, for how many cycles, whose turn is next.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 3;
  int m_sel   = 0;

  task automatic model_step(input logic rn, input logic [3:0] r);
    logic [3:0] others;
    int         c;
    if (!rn) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_sel   = 0;
    end else if (m_owner >= 0) begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (m_held >= HM && others != 4'b0000))
        m_owner = -1;
      else
        m_held = m_held + 1;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        c = (m_last + k) % 4;
        if (r[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_sel  = m_owner;
        m_held = 1;
      end
    end
  endtask

  task automatic drive(input logic rn, input logic [3:0] r);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rn;
    bus.req = r;
    model_step(rn, r);
    e.cyc   = cyc + 1;
    e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0);
    sb.push_back(e);
  endtask

  task automatic drive_n(input int n, input logic rn, input logic [3:0] r);
    for (int i = 0; i < n; i++) drive(rn, r);
  endtask

  initial begin
    logic [3:0] r;
    bus.req = 4'b0000;
    drive_n(3, 1'b0, 4'b0000);
    drive_n(4, 1'b1, 4'b0001);
    drive_n(4, 1'b1, 4'b0000);
    drive_n(80, 1'b1, 4'b1111);
    drive_n(3, 1'b1, 4'b0000);
    drive_n(50, 1'b1, 4'b0100);
    drive_n(3, 1'b1, 4'b0000);
    // b granted, drops exactly on its limit cycle while d waits
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0010);
    drive_n(7, 1'b1, 4'b1010);
    drive_n(3, 1'b1, 4'b1000);
    drive_n(3, 1'b1, 4'b0000);
    // one-cycle reset pulse in the middle of a grant to c
    drive_n(5, 1'b1, 4'b0100);
    drive(1'b0, 4'b1111);
    drive_n(12, 1'b1, 4'b1111);
    r = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      drive(1'b1, r);
    end
    drive_n(3, 1'b1, 4'b0000);
    stim_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual cycle=%0d", cyc);
    $fatal(1);
  end

  logic [3:0] mon_g;
  logic [1:0] mon_s;
  int         mon_gi;
  int         wait_cnt [4];
  int         max_wait;
  exp_t       mon_e;

  always @(negedge clk) begin
    mon_g = bus.gnt;
    mon_s = {bus.s1, bus.s2};
    if (cyc >= 1) begin
      checks++;
      if (!$onehot0(mon_g)) begin
        errors++;
        $display("FAIL onehot cyc=%0d actual gnt=%b required at most one bit", cyc, mon_g);
      end
      checks++;
      if (bus.valid !== (|mon_g)) begin
        errors++;
        $display("FAIL valid_vs_gnt cyc=%0d actual valid=%b required %b", cyc, bus.valid, |mon_g);
      end
      if (bus.valid === 1'b1) begin
        mon_gi = 0;
        for (int i = 0; i < 4; i++) if (mon_g[i]) mon_gi = i;
        checks++;
        if (mon_s !== 2'(mon_gi)) begin
          errors++;
          $display("FAIL sel_vs_gnt cyc=%0d actual sel=%b required %b", cyc, mon_s, 2'(mon_gi));
        end
      end
      // The cycle a request first appears is spent arbitrating, not waiting.
      max_wait = 0;
      for (int i = 0; i < 4; i++) begin
        if (!reset_n || !bus.req[i] || mon_g[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      checks++;
      if (max_wait > WAIT_MAX + 1) begin
        errors++;
        $display("FAIL starvation cyc=%0d actual wait=%0d required <= %0d", cyc, max_wait, WAIT_MAX + 1);
      end
    end

    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL stale_entry cyc=%0d actual target=%0d required %0d", cyc, mon_e.cyc, cyc);
      end else if (mon_g !== mon_e.gnt || mon_s !== mon_e.sel || bus.valid !== mon_e.valid) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual gnt=%b sel=%b valid=%b required gnt=%b sel=%b valid=%b",
                 cyc, mon_g, mon_s, bus.valid, mon_e.gnt, mon_e.sel, mon_e.valid);
      end
    end

    if (stim_done) begin
      drain++;
      if (drain == 3) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL drain actual pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
`default_nettype wire
